// File: rtl/stop_it_param.sv
// -----------------------------------------------------------------------------
// stop_it_param -- parametrised Stop-It game core.
//
// A down-counter (digits 1:0) runs while the player tries to hit stop when it
// equals an 8-bit target (digits 3:2). Correct stops raise the score shown as a
// thermometer on the LEDs; WIN_SCORE correct stops end the game in WON, which
// holds until reset.
//
// Optional feature macro: STOP_IT_SPEEDUP_EN
//   defined   -> decrement period = max(1, STEP_TICKS >> (score/4)), sampled on
//                each entry to DECREMENTING and held for that round.
//   undefined -> decrement period is always STEP_TICKS.
//
// Ports:
//   clk_4_i                 game clock, rising edge
//   rst_ni                  asynchronous active-low reset
//   go_i                    start a round (WAITING_TO_START only)
//   stop_i                  stop the counter (DECREMENTING only)
//   load_i                  load target from switches_i[7:0] (WAITING_TO_START only)
//   switches_i[15:0]        [7:0] target source, [15:8] unused
//   leds_o[15:0]            score thermometer / win flash
//   digitN_en_o             seven-segment digit enables (N = 0..3)
//   digit0_o / digit1_o     counter low / high nibble
//   digit2_o / digit3_o     target low / high nibble
// -----------------------------------------------------------------------------
package stop_it_pkg;
  typedef enum logic [2:0] {
    WAITING_TO_START,
    STARTING,
    DECREMENTING,
    CORRECT,
    WRONG,
    WON
  } state_t;
endpackage

module stop_it_param #(
  parameter int unsigned TICKS_PER_S   = 4,
  parameter int unsigned START_WAIT_S  = 2,
  parameter int unsigned RESULT_WAIT_S = 4,
  parameter int unsigned WIN_SCORE     = 17,
  parameter logic [7:0]  COUNT_INIT    = 8'h1F,
  parameter logic [7:0]  TARGET_INIT   = 8'h00,
  parameter int unsigned STEP_TICKS    = 1
) (
  input  logic        clk_4_i,
  input  logic        rst_ni,
  input  logic        go_i,
  input  logic        stop_i,
  input  logic        load_i,
  input  logic [15:0] switches_i,
  output logic [15:0] leds_o,
  output logic        digit0_en_o,
  output logic        digit1_en_o,
  output logic        digit2_en_o,
  output logic        digit3_en_o,
  output logic [3:0]  digit0_o,
  output logic [3:0]  digit1_o,
  output logic [3:0]  digit2_o,
  output logic [3:0]  digit3_o
);
  import stop_it_pkg::*;

  localparam int unsigned START_CYC  = START_WAIT_S * TICKS_PER_S;
  localparam int unsigned RESULT_CYC = RESULT_WAIT_S * TICKS_PER_S;
  localparam int unsigned MAX_WAIT   = (START_CYC > RESULT_CYC) ? START_CYC : RESULT_CYC;
  localparam int unsigned TIMER_W    = $clog2(MAX_WAIT) + 1;
  // Wide enough to hold STEP_TICKS itself.
  localparam int unsigned STEP_W     = $clog2(STEP_TICKS + 1);

  localparam logic [TIMER_W-1:0] START_LAST  = TIMER_W'(START_CYC - 1);
  localparam logic [TIMER_W-1:0] RESULT_LAST = TIMER_W'(RESULT_CYC - 1);
  localparam logic [7:0]         WIN_SCORE_L = 8'(WIN_SCORE);
  localparam logic [31:0]        STEP_TICKS_L = 32'(STEP_TICKS);

  state_t              state_q, state_next;
  logic [7:0]          counter_reg, counter_next;
  logic [7:0]          target_reg, target_next;
  logic [7:0]          score_reg, score_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic [STEP_W-1:0]   step_cnt_reg, step_cnt_next;
  logic [STEP_W-1:0]   period_reg, period_next;
  logic [STEP_W-1:0]   round_period;
  logic [15:0]         thermo;

  // Upper switches carry no function in this core.
  logic unused_switches;
  assign unused_switches = &{1'b0, switches_i[15:8]};

  // Decrement period to use for the round about to start.
`ifdef STOP_IT_SPEEDUP_EN
  logic [31:0] shifted_period;
  always_comb begin
    shifted_period = STEP_TICKS_L >> score_reg[7:2];
    if (shifted_period == 32'd0) begin
      round_period = STEP_W'(1);
    end else begin
      round_period = STEP_W'(shifted_period);
    end
  end
`else
  assign round_period = STEP_W'(STEP_TICKS_L);
`endif

  always_ff @(posedge clk_4_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= WAITING_TO_START;
      counter_reg  <= COUNT_INIT;
      target_reg   <= TARGET_INIT;
      score_reg    <= 8'd0;
      timer_reg    <= '0;
      step_cnt_reg <= '0;
      period_reg   <= STEP_W'(STEP_TICKS_L);
    end else begin
      state_q      <= state_next;
      counter_reg  <= counter_next;
      target_reg   <= target_next;
      score_reg    <= score_next;
      timer_reg    <= timer_next;
      step_cnt_reg <= step_cnt_next;
      period_reg   <= period_next;
    end
  end

  always_comb begin
    state_next    = state_q;
    counter_next  = counter_reg;
    target_next   = target_reg;
    score_next    = score_reg;
    step_cnt_next = step_cnt_reg;
    period_next   = period_reg;

    case (state_q)
      WAITING_TO_START: begin
        if (load_i) target_next = switches_i[7:0];
        if (go_i)   state_next  = STARTING;
      end
      STARTING: begin
        if (timer_reg == START_LAST) begin
          state_next    = DECREMENTING;
          counter_next  = COUNT_INIT;
          step_cnt_next = '0;
          period_next   = round_period;
        end
      end
      DECREMENTING: begin
        if (stop_i) begin
          // Counter freezes on the stop edge; score bumps on entry to CORRECT.
          if (counter_reg == target_reg) begin
            state_next = CORRECT;
            if (score_reg != 8'hFF) score_next = score_reg + 8'd1;
          end else begin
            state_next = WRONG;
          end
        end else if (step_cnt_reg == period_reg - STEP_W'(1)) begin
          counter_next  = counter_reg - 8'd1;
          step_cnt_next = '0;
        end else begin
          step_cnt_next = step_cnt_reg + STEP_W'(1);
        end
      end
      CORRECT: begin
        if (timer_reg == RESULT_LAST) begin
          state_next = (score_reg == WIN_SCORE_L) ? WON : WAITING_TO_START;
        end
      end
      WRONG: begin
        if (timer_reg == RESULT_LAST) state_next = WAITING_TO_START;
      end
      WON: begin
        state_next = WON;
      end
      default: begin
        state_next = WAITING_TO_START;
      end
    endcase

    // Timer restarts on every state change; in WON it free-runs and only
    // bit 0 is used to flash the LEDs.
    if (state_next != state_q) begin
      timer_next = '0;
    end else begin
      timer_next = timer_reg + TIMER_W'(1);
    end
  end

  // Score thermometer: LED i lit while score exceeds i.
  for (genvar gi = 0; gi < 16; gi++) begin : g_thermo
    assign thermo[gi] = (score_reg > 8'(gi));
  end

  assign leds_o = (state_q == WON) ? (timer_reg[0] ? 16'h0000 : 16'hFFFF) : thermo;

  // Blinking digits start dark on the entry cycle (timer 0).
  assign digit0_en_o = (state_q == CORRECT) ? timer_reg[0] : 1'b1;
  assign digit1_en_o = (state_q == CORRECT) ? timer_reg[0] : 1'b1;
  assign digit2_en_o = (state_q == WRONG)   ? timer_reg[0] : 1'b1;
  assign digit3_en_o = (state_q == WRONG)   ? timer_reg[0] : 1'b1;

  assign digit0_o = counter_reg[3:0];
  assign digit1_o = counter_reg[7:4];
  assign digit2_o = target_reg[3:0];
  assign digit3_o = target_reg[7:4];

endmodule

// File: tb/tb_stop_it_param.sv
// -----------------------------------------------------------------------------
// tb_stop_it_param -- directed checks of stop_it_param.
// u_d0: default parameters; u_d1: WIN_SCORE=3; u_d2: STEP_TICKS=8.
// -----------------------------------------------------------------------------
module tb_stop_it_param;
  import stop_it_pkg::*;

  logic        clk;
  logic        rst_n [3];
  logic        go    [3];
  logic        stop  [3];
  logic        load  [3];
  logic [15:0] sw    [3];
  logic [15:0] leds  [3];
  logic        en0 [3], en1 [3], en2 [3], en3 [3];
  logic [3:0]  dg0 [3], dg1 [3], dg2 [3], dg3 [3];
  state_t      st  [3];

  int checks = 0;
  int passed = 0;

`ifdef STOP_IT_SPEEDUP_EN
  localparam logic [7:0] SPD_AFTER4 = 8'h1E;
  localparam logic [7:0] SPD_AFTER8 = 8'h1D;
`else
  localparam logic [7:0] SPD_AFTER4 = 8'h1F;
  localparam logic [7:0] SPD_AFTER8 = 8'h1E;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stop_it_param u_d0 (
    .clk_4_i(clk), .rst_ni(rst_n[0]), .go_i(go[0]), .stop_i(stop[0]), .load_i(load[0]),
    .switches_i(sw[0]), .leds_o(leds[0]),
    .digit0_en_o(en0[0]), .digit1_en_o(en1[0]), .digit2_en_o(en2[0]), .digit3_en_o(en3[0]),
    .digit0_o(dg0[0]), .digit1_o(dg1[0]), .digit2_o(dg2[0]), .digit3_o(dg3[0]));

  stop_it_param #(.WIN_SCORE(3)) u_d1 (
    .clk_4_i(clk), .rst_ni(rst_n[1]), .go_i(go[1]), .stop_i(stop[1]), .load_i(load[1]),
    .switches_i(sw[1]), .leds_o(leds[1]),
    .digit0_en_o(en0[1]), .digit1_en_o(en1[1]), .digit2_en_o(en2[1]), .digit3_en_o(en3[1]),
    .digit0_o(dg0[1]), .digit1_o(dg1[1]), .digit2_o(dg2[1]), .digit3_o(dg3[1]));

  stop_it_param #(.STEP_TICKS(8)) u_d2 (
    .clk_4_i(clk), .rst_ni(rst_n[2]), .go_i(go[2]), .stop_i(stop[2]), .load_i(load[2]),
    .switches_i(sw[2]), .leds_o(leds[2]),
    .digit0_en_o(en0[2]), .digit1_en_o(en1[2]), .digit2_en_o(en2[2]), .digit3_en_o(en3[2]),
    .digit0_o(dg0[2]), .digit1_o(dg1[2]), .digit2_o(dg2[2]), .digit3_o(dg3[2]));

  assign st[0] = u_d0.state_q;
  assign st[1] = u_d1.state_q;
  assign st[2] = u_d2.state_q;

  function automatic logic [7:0] cnt(input int i);
    return {dg1[i], dg0[i]};
  endfunction

  function automatic logic [7:0] tgt(input int i);
    return {dg3[i], dg2[i]};
  endfunction

  function automatic logic [3:0] ens(input int i);
    return {en3[i], en2[i], en1[i], en0[i]};
  endfunction

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Load target 8'h1C, start, wait dec_steps after entering DECREMENTING, then stop.
  task automatic play_stop(input int i, input int dec_steps);
    load[i] = 1'b1; sw[i] = 16'h001C; go[i] = 1'b1;
    step(1);
    load[i] = 1'b0; go[i] = 1'b0;
    step(8);
    step(dec_steps);
    stop[i] = 1'b1;
    step(1);
    stop[i] = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; go[i] = 1'b0; stop[i] = 1'b0; load[i] = 1'b0; sw[i] = 16'h0000;
    end
    step(2);
    checks++; if (st[0] !== WAITING_TO_START) $display("FAIL rst_state got=%0d exp=%0d", st[0], WAITING_TO_START); else passed++;
    checks++; if (cnt(0) !== 8'h1F) $display("FAIL rst_counter got=%h exp=1f", cnt(0)); else passed++;
    checks++; if (tgt(0) !== 8'h00) $display("FAIL rst_target got=%h exp=00", tgt(0)); else passed++;
    checks++; if (leds[0] !== 16'h0000) $display("FAIL rst_leds got=%h exp=0000", leds[0]); else passed++;
    checks++; if (ens(0) !== 4'hF) $display("FAIL rst_enables got=%h exp=f", ens(0)); else passed++;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    step(1);
    $display("test_reset done");
  endtask

  task automatic test_start;
    go[0] = 1'b1;
    step(1);
    go[0] = 1'b0;
    checks++; if (st[0] !== STARTING) $display("FAIL start_next_edge got=%0d exp=%0d", st[0], STARTING); else passed++;
    step(7);
    checks++; if (st[0] !== STARTING) $display("FAIL start_hold7 got=%0d exp=%0d", st[0], STARTING); else passed++;
    step(1);
    checks++; if (st[0] !== DECREMENTING) $display("FAIL start_to_dec got=%0d exp=%0d", st[0], DECREMENTING); else passed++;
    checks++; if (cnt(0) !== 8'h1F) $display("FAIL start_count_init got=%h exp=1f", cnt(0)); else passed++;
    step(1);
    checks++; if (cnt(0) !== 8'h1E) $display("FAIL start_first_dec got=%h exp=1e", cnt(0)); else passed++;
    stop[0] = 1'b1;
    step(1);
    stop[0] = 1'b0;
    step(16);
    checks++; if (st[0] !== WAITING_TO_START) $display("FAIL start_back_wait got=%0d exp=%0d", st[0], WAITING_TO_START); else passed++;
    $display("test_start done");
  endtask

  task automatic test_correct;
    load[0] = 1'b1; sw[0] = 16'h001C; go[0] = 1'b1;
    step(1);
    load[0] = 1'b0; go[0] = 1'b0;
    checks++; if (tgt(0) !== 8'h1C) $display("FAIL corr_load got=%h exp=1c", tgt(0)); else passed++;
    checks++; if (st[0] !== STARTING) $display("FAIL corr_go_with_load got=%0d exp=%0d", st[0], STARTING); else passed++;
    step(8);
    step(3);
    checks++; if (cnt(0) !== 8'h1C) $display("FAIL corr_count got=%h exp=1c", cnt(0)); else passed++;
    stop[0] = 1'b1;
    step(1);
    stop[0] = 1'b0;
    checks++; if (st[0] !== CORRECT) $display("FAIL corr_state got=%0d exp=%0d", st[0], CORRECT); else passed++;
    checks++; if (leds[0] !== 16'h0001) $display("FAIL corr_leds got=%h exp=0001", leds[0]); else passed++;
    checks++; if (ens(0) !== 4'hC) $display("FAIL corr_blink0 got=%h exp=c", ens(0)); else passed++;
    checks++; if (cnt(0) !== 8'h1C) $display("FAIL corr_frozen got=%h exp=1c", cnt(0)); else passed++;
    step(1);
    checks++; if (ens(0) !== 4'hF) $display("FAIL corr_blink1 got=%h exp=f", ens(0)); else passed++;
    step(14);
    checks++; if (st[0] !== CORRECT) $display("FAIL corr_hold15 got=%0d exp=%0d", st[0], CORRECT); else passed++;
    step(1);
    checks++; if (st[0] !== WAITING_TO_START) $display("FAIL corr_exit got=%0d exp=%0d", st[0], WAITING_TO_START); else passed++;
    checks++; if (leds[0] !== 16'h0001) $display("FAIL corr_leds_after got=%h exp=0001", leds[0]); else passed++;
    $display("test_correct done");
  endtask

  task automatic test_wrong;
    go[0] = 1'b1;
    step(1);
    go[0] = 1'b0;
    step(8);
    step(5);
    checks++; if (cnt(0) !== 8'h1A) $display("FAIL wrong_count got=%h exp=1a", cnt(0)); else passed++;
    stop[0] = 1'b1;
    step(1);
    stop[0] = 1'b0;
    checks++; if (st[0] !== WRONG) $display("FAIL wrong_state got=%0d exp=%0d", st[0], WRONG); else passed++;
    checks++; if (ens(0) !== 4'h3) $display("FAIL wrong_blink0 got=%h exp=3", ens(0)); else passed++;
    checks++; if (leds[0] !== 16'h0001) $display("FAIL wrong_leds got=%h exp=0001", leds[0]); else passed++;
    step(1);
    checks++; if (ens(0) !== 4'hF) $display("FAIL wrong_blink1 got=%h exp=f", ens(0)); else passed++;
    step(14);
    checks++; if (st[0] !== WRONG) $display("FAIL wrong_hold15 got=%0d exp=%0d", st[0], WRONG); else passed++;
    step(1);
    checks++; if (st[0] !== WAITING_TO_START) $display("FAIL wrong_exit got=%0d exp=%0d", st[0], WAITING_TO_START); else passed++;
    checks++; if (leds[0] !== 16'h0001) $display("FAIL wrong_leds_after got=%h exp=0001", leds[0]); else passed++;
    $display("test_wrong done");
  endtask

  task automatic test_wrap_ignore;
    stop[0] = 1'b1;
    step(1);
    stop[0] = 1'b0;
    checks++; if (st[0] !== WAITING_TO_START) $display("FAIL ign_stop_wait got=%0d exp=%0d", st[0], WAITING_TO_START); else passed++;
    go[0] = 1'b1;
    step(1);
    go[0] = 1'b0;
    step(8);
    step(31);
    checks++; if (cnt(0) !== 8'h00) $display("FAIL wrap_zero got=%h exp=00", cnt(0)); else passed++;
    go[0] = 1'b1; load[0] = 1'b1; sw[0] = 16'h0055;
    step(1);
    checks++; if (cnt(0) !== 8'hFF) $display("FAIL wrap_ff got=%h exp=ff", cnt(0)); else passed++;
    checks++; if (st[0] !== DECREMENTING) $display("FAIL ign_go_dec got=%0d exp=%0d", st[0], DECREMENTING); else passed++;
    checks++; if (tgt(0) !== 8'h1C) $display("FAIL ign_load_dec got=%h exp=1c", tgt(0)); else passed++;
    step(1);
    go[0] = 1'b0; load[0] = 1'b0;
    checks++; if (cnt(0) !== 8'hFE) $display("FAIL wrap_fe got=%h exp=fe", cnt(0)); else passed++;
    stop[0] = 1'b1;
    step(1);
    stop[0] = 1'b0;
    checks++; if (st[0] !== WRONG) $display("FAIL wrap_stop_wrong got=%0d exp=%0d", st[0], WRONG); else passed++;
    step(16);
    checks++; if (st[0] !== WAITING_TO_START) $display("FAIL wrap_exit got=%0d exp=%0d", st[0], WAITING_TO_START); else passed++;
    $display("test_wrap_ignore done");
  endtask

  task automatic test_win;
    play_stop(1, 3);
    step(16);
    checks++; if (leds[1] !== 16'h0001) $display("FAIL win_score1 got=%h exp=0001", leds[1]); else passed++;
    play_stop(1, 3);
    step(16);
    checks++; if (leds[1] !== 16'h0003) $display("FAIL win_score2 got=%h exp=0003", leds[1]); else passed++;
    checks++; if (st[1] !== WAITING_TO_START) $display("FAIL win_not_yet got=%0d exp=%0d", st[1], WAITING_TO_START); else passed++;
    play_stop(1, 3);
    checks++; if (leds[1] !== 16'h0007) $display("FAIL win_score3 got=%h exp=0007", leds[1]); else passed++;
    step(15);
    checks++; if (st[1] !== CORRECT) $display("FAIL win_hold15 got=%0d exp=%0d", st[1], CORRECT); else passed++;
    step(1);
    checks++; if (st[1] !== WON) $display("FAIL win_state got=%0d exp=%0d", st[1], WON); else passed++;
    checks++; if (leds[1] !== 16'hFFFF) $display("FAIL win_flash0 got=%h exp=ffff", leds[1]); else passed++;
    step(1);
    checks++; if (leds[1] !== 16'h0000) $display("FAIL win_flash1 got=%h exp=0000", leds[1]); else passed++;
    go[1] = 1'b1; stop[1] = 1'b1; load[1] = 1'b1; sw[1] = 16'h0077;
    step(1);
    go[1] = 1'b0; stop[1] = 1'b0; load[1] = 1'b0;
    checks++; if (leds[1] !== 16'hFFFF) $display("FAIL win_flash2 got=%h exp=ffff", leds[1]); else passed++;
    checks++; if (st[1] !== WON) $display("FAIL win_ignore_in got=%0d exp=%0d", st[1], WON); else passed++;
    checks++; if (tgt(1) !== 8'h1C) $display("FAIL win_ignore_load got=%h exp=1c", tgt(1)); else passed++;
    rst_n[1] = 1'b0;
    #1;
    checks++; if (st[1] !== WAITING_TO_START) $display("FAIL win_async_rst got=%0d exp=%0d", st[1], WAITING_TO_START); else passed++;
    checks++; if (leds[1] !== 16'h0000) $display("FAIL win_rst_score got=%h exp=0000", leds[1]); else passed++;
    checks++; if (tgt(1) !== 8'h00) $display("FAIL win_rst_target got=%h exp=00", tgt(1)); else passed++;
    step(1);
    rst_n[1] = 1'b1;
    $display("test_win done");
  endtask

  task automatic test_speed;
    play_stop(2, 24);
    checks++; if (st[2] !== CORRECT) $display("FAIL spd_round1 got=%0d exp=%0d", st[2], CORRECT); else passed++;
    checks++; if (cnt(2) !== 8'h1C) $display("FAIL spd_step8 got=%h exp=1c", cnt(2)); else passed++;
    step(16);
    for (int r = 0; r < 3; r++) begin
      play_stop(2, 24);
      step(16);
    end
    checks++; if (leds[2] !== 16'h000F) $display("FAIL spd_score4 got=%h exp=000f", leds[2]); else passed++;
    go[2] = 1'b1;
    step(1);
    go[2] = 1'b0;
    step(8);
    step(3);
    checks++; if (cnt(2) !== 8'h1F) $display("FAIL spd_3cyc got=%h exp=1f", cnt(2)); else passed++;
    step(1);
    checks++; if (cnt(2) !== SPD_AFTER4) $display("FAIL spd_4cyc got=%h exp=%h", cnt(2), SPD_AFTER4); else passed++;
    step(4);
    checks++; if (cnt(2) !== SPD_AFTER8) $display("FAIL spd_8cyc got=%h exp=%h", cnt(2), SPD_AFTER8); else passed++;
    $display("test_speed done");
  endtask

  initial begin
    test_reset();
    test_start();
    test_correct();
    test_wrong();
    test_wrap_ignore();
    test_win();
    test_speed();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
